// File: rtl/switch_debounce.sv
// Four-channel push-button debouncer. Each channel has a 2-flop synchronizer, a stability
// counter, and a hold timer. Outputs are the debounced level and press/release/long-press pulses.
module switch_debounce #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Level,
  output logic [3:0] o_Press,
  output logic [3:0] o_Release,
  output logic [3:0] o_Long
);

  localparam int DB = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LP = CLK_FREQ / 1000 * LONG_MS;
  localparam int DW = $clog2(DB + 1);
  localparam int LW = $clog2(LP + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DB - 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LP - 1);
  localparam logic [LW-1:0] LP_MAX  = LW'(LP);

  logic [3:0]    meta;
  logic [3:0]    sync;
  logic [DW-1:0] db_cnt   [4];
  logic [LW-1:0] hold_cnt [4];
  logic [3:0]    flip;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= i_Switch;
      sync <= meta;
    end
  end

  // A channel flips its debounced level on this edge.
  always_comb begin
    flip = '0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      flip[ch] = (sync[ch] != o_Level[ch]) && (db_cnt[ch] == DB_LAST);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Level   <= '0;
      o_Press   <= '0;
      o_Release <= '0;
      o_Long    <= '0;
      for (int unsigned ch = 0; ch < 4; ch++) begin
        db_cnt[ch]   <= '0;
        hold_cnt[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 4; ch++) begin
        o_Press[ch]   <= 1'b0;
        o_Release[ch] <= 1'b0;
        o_Long[ch]    <= 1'b0;

        if (sync[ch] == o_Level[ch]) begin
          db_cnt[ch] <= '0;
        end else if (flip[ch]) begin
          db_cnt[ch]    <= '0;
          o_Level[ch]   <= sync[ch];
          o_Press[ch]   <= sync[ch];
          o_Release[ch] <= ~sync[ch];
        end else begin
          db_cnt[ch] <= db_cnt[ch] + 1'b1;
        end

        if (!o_Level[ch]) begin
          hold_cnt[ch] <= '0;
        end else if (hold_cnt[ch] != LP_MAX) begin
          hold_cnt[ch] <= hold_cnt[ch] + 1'b1;
        end

        // A release on the same edge wins, so long and release never coincide.
        if (o_Level[ch] && (hold_cnt[ch] == LP_LAST) && !flip[ch]) begin
          o_Long[ch] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DB=4 and LP=20 cycles.
module tb_switch_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sw  = '0;
  logic [3:0] level, press, release_p, long_p;

  int total = 0;
  int fails = 0;

  switch_debounce #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Switch (sw),
    .o_Level  (level),
    .o_Press  (press),
    .o_Release(release_p),
    .o_Long   (long_p)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] all_out();
    return {level, press, release_p, long_p};
  endfunction

  function automatic logic [15:0] chan(input int c);
    return {12'h000, level[c], press[c], release_p[c], long_p[c]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Async reset with all switches held.
    sw = 4'hF;
    #1 rst = 1'b1;
    #1 chk("rst_async", all_out(), 16'h0000);
    tick();
    tick();
    chk("rst_held", all_out(), 16'h0000);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("rst_release_wait", all_out(), 16'h0000);
    end
    tick();
    chk("rst_release_press", all_out(), 16'hFF00);
    tick();
    chk("rst_release_after", all_out(), 16'hF000);

    // Release all four.
    sw = 4'h0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("all_release_wait", all_out(), 16'hF000);
    end
    tick();
    chk("all_release_pulse", all_out(), 16'h00F0);
    tick();
    chk("all_release_after", all_out(), 16'h0000);
    repeat (5) tick();

    // Channel 0 clean press then release.
    sw = 4'h1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("ch0_press_wait", all_out(), 16'h0000);
    end
    tick();
    chk("ch0_press", all_out(), 16'h1100);
    tick();
    chk("ch0_press_after", all_out(), 16'h1000);
    sw = 4'h0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("ch0_rel_wait", all_out(), 16'h1000);
    end
    tick();
    chk("ch0_release", all_out(), 16'h0010);
    tick();
    chk("ch0_rel_after", all_out(), 16'h0000);
    repeat (5) tick();

    // Channel 1 bounces every 2 cycles for 12 cycles, then settles high.
    for (int k = 0; k < 6; k++) begin
      sw[1] = (k % 2 == 0);
      repeat (2) begin
        tick();
        chk("ch1_bounce", chan(1), 16'h0);
      end
    end
    sw[1] = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("ch1_settle_wait", chan(1), 16'h0);
    end
    tick();
    chk("ch1_press", chan(1), 16'hC);
    tick();
    chk("ch1_press_after", chan(1), 16'h8);
    sw[1] = 1'b0;
    repeat (5) tick();
    chk("ch1_rel_wait", chan(1), 16'h8);
    tick();
    chk("ch1_release", chan(1), 16'h2);
    repeat (5) tick();

    // Channel 2 glitch of 3 cycles is rejected.
    sw[2] = 1'b1;
    repeat (3) tick();
    sw[2] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      chk("ch2_glitch", chan(2), 16'h0);
    end

    // Channel 3 held 30 cycles: long pulse at 26, release pulse at 36.
    sw[3] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      if (t == 31) sw[3] = 1'b0;
      tick();
      chk("ch3_long_hold", chan(3),
          {12'h000, (t >= 6 && t < 36), (t == 6), (t == 36), (t == 26)});
    end

    // Channel 3 held 10 cycles: no long pulse.
    sw[3] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) sw[3] = 1'b0;
      tick();
      chk("ch3_short_hold", chan(3),
          {12'h000, (t >= 6 && t < 16), (t == 6), (t == 16), 1'b0});
    end

    // Channels 0 and 3 together, reset mid-hold.
    sw = 4'h9;
    repeat (5) tick();
    chk("pair_wait", all_out(), 16'h0000);
    tick();
    chk("pair_press", all_out(), 16'h9900);
    repeat (4) tick();
    chk("pair_hold", all_out(), 16'h9000);
    rst = 1'b1;
    #1 chk("pair_rst_async", all_out(), 16'h0000);
    sw = 4'h0;
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      chk("pair_after_rst", all_out(), 16'h0000);
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter CLK_FREQ, default 25_000_000, input clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, stability time in ms; DB = CLK_FREQ/1000*DEBOUNCE_MS cycles; DB SHALL be >= 1.
REQ-003 Parameter LONG_MS, default 1000, long-press time in ms; LP = CLK_FREQ/1000*LONG_MS cycles; LP SHALL be >= 1.
REQ-004 i_Clk  input  1  sole clock, all logic on rising edge.
REQ-005 i_Rst  input  1  reset, asynchronous, active-high.
REQ-006 i_Switch  input  4  raw board push-buttons, asynchronous to i_Clk, 1 = pressed.
REQ-007 o_Level  output  4  debounced switch state per channel.
REQ-008 o_Press  output  4  one-cycle pulse per channel on debounced 0->1.
REQ-009 o_Release  output  4  one-cycle pulse per channel on debounced 1->0.
REQ-010 o_Long  output  4  one-cycle pulse per channel when held for LP cycles.

Function
REQ-011 Four identical, fully independent channels; no interaction between channels.
REQ-012 Each i_Switch bit SHALL pass through a 2-flop synchronizer (value s) before any other use.
REQ-013 Stability counter per channel, width $clog2(DB+1): s == o_Level -> counter cleared; s != o_Level -> counter increments.
REQ-014 When counter is DB-1 and s != o_Level on an edge: o_Level <= s, counter <= 0.
REQ-015 Pin-to-o_Level latency SHALL be exactly 2+DB cycles for a clean edge; any bounce restarts the DB window.
REQ-016 o_Press (o_Release) SHALL be high exactly in the cycle after o_Level rises (falls) is first visible, i.e. registered on the same edge that updates o_Level; one cycle wide.
REQ-017 Hold counter per channel, width $clog2(LP+1): cleared while o_Level == 0; increments each cycle o_Level == 1; saturates at LP.
REQ-018 o_Long SHALL pulse once, LP cycles after the o_Press pulse, only if o_Level stays 1 throughout; no repeat until release and new press.
REQ-019 Release before LP: o_Release pulses, o_Long never asserted for that press.
REQ-020 o_Press, o_Release, o_Long SHALL never be high simultaneously on one channel.
REQ-021 All outputs registered; no combinational path from i_Switch to any output.

Reset
REQ-022 i_Rst high SHALL immediately clear synchronizers, counters, o_Level, o_Press, o_Release, o_Long to 0, independent of i_Clk.
REQ-023 Reset mid-hold: o_Level drops to 0 with no o_Release pulse; no o_Long for that hold.
REQ-024 Switch held through reset deassertion: o_Level rises and o_Press pulses 2+DB edges after deassertion (first edge counted as 1).

Verification (CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_MS=20 -> DB=4, LP=20)
REQ-025 Assert i_Rst with i_Switch=4'hF -> all outputs 0 asynchronously, held 0 until 6 edges after deassertion, then o_Level=4'hF and o_Press=4'hF for one cycle.
REQ-026 i_Switch[0] 0->1 clean, held -> o_Level[0]=1 and o_Press[0]=1 at edge 6; o_Press[0]=0 at edge 7.
REQ-027 i_Switch[1] toggles every 2 cycles for 12 cycles then stays 1 -> exactly one o_Press[1], 6 cycles after last transition; o_Release[1] never pulses.
REQ-028 i_Switch[2] high for 3 cycles only -> o_Level[2], o_Press[2], o_Release[2] stay 0.
REQ-029 i_Switch[3] held 30 cycles then released -> o_Long[3] one pulse 20 cycles after o_Press[3]; o_Release[3] 6 cycles after release; hold of 10 cycles -> no o_Long[3].
REQ-030 Channels 0 and 3 pressed same cycle, i_Rst pulsed during hold -> both o_Level clear at once, no o_Release, no o_Long; other channels unaffected before reset.
